fdd_sd_bridge: RTL and testbench

Sector-transfer bridge between the floppy controller's SD request port (`sd_lba`/`sd_rd`/`sd_wr`/buffer bus) and the HPS SD block of the image slot. It arbitrates one request at a time, holds HPS request lines until acknowledged, and aborts on a watchdog timeout. It also keeps a one-sector read cache, so a controller re-reading the same LBA (retries, multi-pass track reads) is served locally without an HPS round-trip.

---
 rtl/fdd_sd_bridge.sv | 160 ++++++++++++++++
 tb/tb_fdd_sd_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdd_sd_bridge.sv
// Sector bridge from the floppy controller SD port to the HPS SD block, with a
// one-sector read cache replayed locally when the same LBA is re-read.
module fdd_sd_bridge #(
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        img_mounted,
    input  logic [31:0] fdc_lba,
    input  logic        fdc_rd,
    input  logic        fdc_wr,
    output logic        fdc_ack,
    output logic [8:0]  fdc_buff_addr,
    output logic [7:0]  fdc_buff_dout,
    input  logic [7:0]  fdc_buff_din,
    output logic        fdc_buff_wr,
    output logic [31:0] hps_lba,
    output logic        hps_rd,
    output logic        hps_wr,
    input  logic        hps_ack,
    input  logic [8:0]  hps_buff_addr,
    input  logic [7:0]  hps_buff_dout,
    input  logic        hps_buff_wr,
    output logic [7:0]  hps_buff_din,
    output logic        error
);

    typedef enum logic [2:0] {StIdle, StHpsRd, StHpsWr, StReplay, StDone} state_e;

    state_e      state;
    logic [31:0] req_lba;
    logic [31:0] cache_lba;
    logic        cache_valid;
    logic        ack_seen;
    logic        mount_seen;
    logic [23:0] wd;
    logic [9:0]  cnt;
    logic [7:0]  ram [512];
    logic [7:0]  ram_q;
    logic [8:0]  ram_raddr;
    logic        cache_hit;

    assign hps_buff_din = fdc_buff_din;
    assign cache_hit    = CACHE_EN && cache_valid && (fdc_lba == cache_lba);
    // Address 0 is pre-read while idle so the first replay byte is ready one cycle after accept.
    assign ram_raddr    = (state == StReplay) ? cnt[8:0] : 9'd0;

    always_ff @(posedge clk) begin
        if (state == StHpsRd && hps_buff_wr) begin
            ram[hps_buff_addr] <= hps_buff_dout;
        end
        ram_q <= ram[ram_raddr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            req_lba       <= '0;
            cache_lba     <= '0;
            cache_valid   <= 1'b0;
            ack_seen      <= 1'b0;
            mount_seen    <= 1'b0;
            wd            <= '0;
            cnt           <= '0;
            fdc_ack       <= 1'b0;
            fdc_buff_addr <= '0;
            fdc_buff_dout <= '0;
            fdc_buff_wr   <= 1'b0;
            hps_lba       <= '0;
            hps_rd        <= 1'b0;
            hps_wr        <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    fdc_ack     <= 1'b0;
                    fdc_buff_wr <= 1'b0;
                    if (fdc_wr || fdc_rd) begin
                        req_lba    <= fdc_lba;
                        wd         <= '0;
                        ack_seen   <= 1'b0;
                        mount_seen <= 1'b0;
                        if (fdc_wr) begin
                            state       <= StHpsWr;
                            hps_wr      <= 1'b1;
                            hps_lba     <= fdc_lba;
                            cache_valid <= 1'b0;
                        end else if (cache_hit) begin
                            state   <= StReplay;
                            fdc_ack <= 1'b1;
                            cnt     <= 10'd1;
                        end else begin
                            state   <= StHpsRd;
                            hps_rd  <= 1'b1;
                            hps_lba <= fdc_lba;
                        end
                    end
                end
                StHpsRd, StHpsWr: begin
                    fdc_ack       <= hps_ack;
                    fdc_buff_addr <= hps_buff_addr;
                    fdc_buff_dout <= hps_buff_dout;
                    fdc_buff_wr   <= hps_buff_wr;
                    if (hps_ack) begin
                        hps_rd   <= 1'b0;
                        hps_wr   <= 1'b0;
                        ack_seen <= 1'b1;
                    end
                    if (ack_seen && !hps_ack) begin
                        state <= StDone;
                        if (state == StHpsRd) begin
                            cache_lba   <= req_lba;
                            cache_valid <= !mount_seen;
                        end
                    end else if (!ack_seen && !hps_ack) begin
                        if (wd == TIMEOUT - 24'd1) begin
                            state       <= StDone;
                            hps_rd      <= 1'b0;
                            hps_wr      <= 1'b0;
                            error       <= 1'b1;
                            cache_valid <= 1'b0;
                            fdc_ack     <= 1'b1;
                            fdc_buff_wr <= 1'b0;
                        end else begin
                            wd <= wd + 24'd1;
                        end
                    end
                end
                StReplay: begin
                    // cnt runs one ahead of the byte being presented, matching the RAM latency.
                    if (cnt == 10'd513) begin
                        state       <= StDone;
                        fdc_ack     <= 1'b0;
                        fdc_buff_wr <= 1'b0;
                    end else begin
                        fdc_buff_wr   <= 1'b1;
                        fdc_buff_addr <= cnt[8:0] - 9'd1;
                        fdc_buff_dout <= ram_q;
                        cnt           <= cnt + 10'd1;
                    end
                end
                StDone: begin
                    fdc_ack     <= 1'b0;
                    fdc_buff_wr <= 1'b0;
                    if (!fdc_rd && !fdc_wr) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
            if (img_mounted) begin
                cache_valid <= 1'b0;
                error       <= 1'b0;
                mount_seen  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fdd_sd_bridge.sv
// Bench for fdd_sd_bridge: directed vector table plus randomized transfers
// checked against a sector-level cache/error model.
module tb_fdd_sd_bridge;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        img_mounted;
    logic [31:0] fdc_lba;
    logic        fdc_rd;
    logic        fdc_wr;
    logic        fdc_ack;
    logic [8:0]  fdc_buff_addr;
    logic [7:0]  fdc_buff_dout;
    logic [7:0]  fdc_buff_din;
    logic        fdc_buff_wr;
    logic [31:0] hps_lba;
    logic        hps_rd;
    logic        hps_wr;
    logic        hps_ack;
    logic [8:0]  hps_buff_addr;
    logic [7:0]  hps_buff_dout;
    logic        hps_buff_wr;
    logic [7:0]  hps_buff_din;
    logic        error;

    fdd_sd_bridge #(
        .TIMEOUT (24'(TMO)),
        .CACHE_EN(1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .fdc_lba      (fdc_lba),
        .fdc_rd       (fdc_rd),
        .fdc_wr       (fdc_wr),
        .fdc_ack      (fdc_ack),
        .fdc_buff_addr(fdc_buff_addr),
        .fdc_buff_dout(fdc_buff_dout),
        .fdc_buff_din (fdc_buff_din),
        .fdc_buff_wr  (fdc_buff_wr),
        .hps_lba      (hps_lba),
        .hps_rd       (hps_rd),
        .hps_wr       (hps_wr),
        .hps_ack      (hps_ack),
        .hps_buff_addr(hps_buff_addr),
        .hps_buff_dout(hps_buff_dout),
        .hps_buff_wr  (hps_buff_wr),
        .hps_buff_din (hps_buff_din),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Sector-level model: what the cache holds and whether the error flag is up.
    logic [7:0]  m_data [512];
    logic [7:0]  stream [512];
    bit          m_valid;
    logic [31:0] m_lba;
    bit          m_err;

    typedef struct {
        bit          wr;
        bit          both;
        logic [31:0] lba;
        bit          respond;
        int          delay;
        int          mount_at;
        bit          mount_after;
        logic [7:0]  wdata;
        bit          exp_hps;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic req_line(input bit wr);
        return wr ? hps_wr : hps_rd;
    endfunction

    task automatic run_xfer(input vec_t v, input bit rnd);
        int bad;
        bit got;
        bit mounted;
        int hi;
        int acks;
        int wrs;
        bad     = 0;
        mounted = 0;
        for (int i = 0; i < 512; i++) stream[i] = rnd ? 8'($urandom) : 8'(i);
        fdc_lba = v.lba;
        fdc_wr  = v.wr;
        fdc_rd  = !v.wr || v.both;
        @(negedge clk);
        got = req_line(v.wr);
        check("hps_req", 32'(got), 32'(v.exp_hps));
        if (v.wr) m_valid = 1'b0;
        if (got) begin
            check("hps_lba", hps_lba, v.lba);
            if (v.respond) begin
                for (int c = 0; c < v.delay; c++) begin
                    if (!req_line(v.wr) || fdc_ack || (v.wr && hps_rd)) bad++;
                    @(negedge clk);
                end
                for (int b = 0; b <= 512; b++) begin
                    logic       cur_ack;
                    logic       cur_wr;
                    logic [8:0] cur_addr;
                    logic [7:0] cur_dout;
                    cur_ack       = (b < 512);
                    cur_wr        = cur_ack && !v.wr;
                    cur_addr      = 9'(b);
                    cur_dout      = cur_ack ? stream[cur_addr] : 8'h00;
                    hps_ack       = cur_ack;
                    hps_buff_wr   = cur_wr;
                    hps_buff_addr = cur_addr;
                    hps_buff_dout = cur_dout;
                    fdc_buff_din  = rnd ? 8'($urandom) : v.wdata;
                    img_mounted   = (b == v.mount_at);
                    if (img_mounted) begin
                        m_valid = 1'b0;
                        m_err   = 1'b0;
                        mounted = 1'b1;
                    end
                    #1;
                    if (v.wr && hps_buff_din !== fdc_buff_din) bad++;
                    @(negedge clk);
                    if (fdc_ack !== cur_ack || fdc_buff_wr !== cur_wr) bad++;
                    if (cur_wr && (fdc_buff_addr !== cur_addr || fdc_buff_dout !== cur_dout)) bad++;
                    if (hps_rd || hps_wr) bad++;
                    if (b == 0) check("hps_req_drop", 32'(req_line(v.wr)), 32'd0);
                end
                img_mounted = 1'b0;
                hps_ack     = 1'b0;
                hps_buff_wr = 1'b0;
                check("passthru", bad, 0);
                if (!v.wr) begin
                    for (int i = 0; i < 512; i++) m_data[i] = stream[i];
                    m_lba   = v.lba;
                    m_valid = !mounted;
                end
            end else begin
                hi   = 0;
                acks = 0;
                wrs  = 0;
                for (int c = 0; c < TMO + 20; c++) begin
                    if (req_line(v.wr)) hi++;
                    if (fdc_ack) acks++;
                    if (fdc_buff_wr) wrs++;
                    @(negedge clk);
                end
                check("tmo_req_cycles", hi, TMO);
                check("tmo_ack_pulse", acks, 1);
                check("tmo_no_strobe", wrs, 0);
                m_valid = 1'b0;
                m_err   = 1'b1;
            end
        end else begin
            if (fdc_ack !== 1'b1 || fdc_buff_wr !== 1'b0) bad++;
            for (int i = 0; i < 512; i++) begin
                @(negedge clk);
                if (fdc_ack !== 1'b1 || fdc_buff_wr !== 1'b1 || fdc_buff_addr !== 9'(i) ||
                    fdc_buff_dout !== m_data[i] || hps_rd || hps_wr) bad++;
            end
            @(negedge clk);
            if (fdc_ack !== 1'b0 || fdc_buff_wr !== 1'b0) bad++;
            check("replay", bad, 0);
        end
        if (v.both) begin
            fdc_wr = 1'b0;
            bad    = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (hps_rd || hps_wr || fdc_ack || fdc_buff_wr) bad++;
            end
            check("done_hold", bad, 0);
        end
        fdc_rd = 1'b0;
        fdc_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("error_flag", 32'(error), 32'(v.exp_err));
        if (v.mount_after) begin
            img_mounted = 1'b1;
            @(negedge clk);
            img_mounted = 1'b0;
            m_valid     = 1'b0;
            m_err       = 1'b0;
            check("error_cleared", 32'(error), 32'd0);
        end
    endtask

    initial begin
        //            wr    both  lba       resp  dly mnt  maft  wdata  hps   err
        vecs[0] = '{1'b0, 1'b0, 32'h25, 1'b1, 5, -1,  1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h25, 1'b1, 0, -1,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h25, 1'b1, 3, -1,  1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h25, 1'b1, 2, -1,  1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h40, 1'b0, 0, -1,  1'b1, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h25, 1'b1, 4, 100, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h25, 1'b1, 1, -1,  1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h25, 1'b1, 0, -1,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'h30, 1'b1, 0, -1,  1'b0, 8'h5C, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'h25, 1'b1, 0, -1,  1'b0, 8'h00, 1'b1, 1'b0};

        reset_n       = 1'b0;
        img_mounted   = 1'b0;
        fdc_lba       = '0;
        fdc_rd        = 1'b0;
        fdc_wr        = 1'b0;
        fdc_buff_din  = '0;
        hps_ack       = 1'b0;
        hps_buff_addr = '0;
        hps_buff_dout = '0;
        hps_buff_wr   = 1'b0;
        m_valid       = 1'b0;
        m_lba         = '0;
        m_err         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs",
              32'({fdc_ack, fdc_buff_wr, hps_rd, hps_wr, error, fdc_buff_addr, fdc_buff_dout}),
              32'd0);
        check("rst_hps_lba", hps_lba, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 10; k++) run_xfer(vecs[k], 1'b0);

        for (int k = 0; k < 14; k++) begin
            vec_t v;
            v.wr   = ($urandom_range(0, 3) == 0);
            v.both = 1'b0;
            case ($urandom_range(0, 2))
                0:       v.lba = 32'h0000_0025;
                1:       v.lba = 32'h1234_5678;
                default: v.lba = 32'h0000_0007;
            endcase
            v.respond     = ($urandom_range(0, 9) != 0);
            v.delay       = $urandom_range(0, 30);
            v.mount_at    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 512)) : -1;
            v.mount_after = ($urandom_range(0, 5) == 0);
            v.wdata       = 8'($urandom);
            v.exp_hps     = v.wr || !(m_valid && m_lba == v.lba);
            if (!v.exp_hps)       v.exp_err = m_err;
            else if (!v.respond)  v.exp_err = 1'b1;
            else if (v.mount_at >= 0) v.exp_err = 1'b0;
            else                  v.exp_err = m_err;
            run_xfer(v, 1'b1);
        end

        // Asynchronous reset in the middle of an HPS transfer.
        fdc_lba = 32'h0000_0099;
        fdc_rd  = 1'b1;
        @(negedge clk);
        hps_ack       = 1'b1;
        hps_buff_wr   = 1'b1;
        hps_buff_addr = 9'd3;
        hps_buff_dout = 8'h5A;
        @(negedge clk);
        check("pre_reset_ack", 32'(fdc_ack), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset",
              32'({fdc_ack, fdc_buff_wr, hps_rd, hps_wr, error, fdc_buff_addr, fdc_buff_dout}),
              32'd0);
        check("async_reset_lba", hps_lba, 32'd0);
        fdc_rd      = 1'b0;
        hps_ack     = 1'b0;
        hps_buff_wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
